demux4_slot: RTL and testbench

Registered 1-to-4 demultiplexer with per-channel handshake: the distribution counterpart of the team's 4-to-1 selector. A source word DIN is steered by select S into one of four single-entry output slots (Y0..Y3). Each slot holds its word with a valid flag until its sink accepts it. A per-channel delivery counter supports lab-board display and bench checking. It sits between a single producer (switches or upstream logic) and four independent consumers.

---
 rtl/demux4_slot_pkg.sv | 31 +++
 rtl/demux4_slot_if.sv | 24 ++
 rtl/demux4_slot_slot.sv | 51 +++++
 rtl/demux4_slot.sv | 51 +++++
 tb/tb_demux4_slot.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/demux4_slot_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// demux4_slot_pkg : shared constants and channel decode for demux4_slot
// Revision 1.0
// ---------------------------------------------------------------------------
package demux4_slot_pkg;

  localparam int NCH    = 4;
  localparam int W_DEF  = 2;
  localparam int CW_DEF = 8;

  localparam logic [1:0] CH0 = 2'b00;
  localparam logic [1:0] CH1 = 2'b01;
  localparam logic [1:0] CH2 = 2'b10;
  localparam logic [1:0] CH3 = 2'b11;

  function automatic logic [NCH-1:0] ch_decode(input logic [1:0] sel);
    logic [NCH-1:0] onehot;
    onehot = '0;
    case (sel)
      CH0:     onehot[0] = 1'b1;
      CH1:     onehot[1] = 1'b1;
      CH2:     onehot[2] = 1'b1;
      CH3:     onehot[3] = 1'b1;
      default: onehot    = '0;
    endcase
    return onehot;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux4_slot_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// demux4_slot_if : producer bus plus four sink channels of demux4_slot
// Revision 1.0
// ---------------------------------------------------------------------------
interface demux4_slot_if
  import demux4_slot_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
);
  logic [W-1:0]             din;
  logic [1:0]               s;
  logic                     en;
  logic                     rdy;
  logic [NCH-1:0][W-1:0]    y;
  logic [NCH-1:0]           v;
  logic [NCH-1:0]           r;
  logic [NCH-1:0][CW-1:0]   cnt;

  modport master (output din, s, en, r, input rdy, y, v, cnt);
  modport slave  (input din, s, en, r, output rdy, y, v, cnt);
endinterface
`default_nettype wire

// File: rtl/demux4_slot_slot.sv
`default_nettype none
// ---------------------------------------------------------------------------
// demux_slot : single-entry output slot with valid flag and delivery counter
// Revision 1.0
// ---------------------------------------------------------------------------
module demux_slot #(
  parameter int W  = 2,
  parameter int CW = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          i_load,
  input  wire logic [W-1:0]  i_load_data,
  input  wire logic          i_sink_rdy,
  output logic               o_free,
  output logic [W-1:0]       o_y,
  output logic               o_v,
  output logic [CW-1:0]      o_cnt
);
  logic [W-1:0]  r_y;
  logic          r_v;
  logic [CW-1:0] r_cnt;
  logic          w_drain;

  assign w_drain = r_v & i_sink_rdy;
  assign o_free  = ~r_v | i_sink_rdy;

  // A reload in the draining cycle wins over the clear, so the slot never bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y   <= '0;
      r_v   <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (i_load) begin
        r_y <= i_load_data;
        r_v <= 1'b1;
      end else if (w_drain) begin
        r_v <= 1'b0;
      end
      if (w_drain) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_y   = r_y;
  assign o_v   = r_v;
  assign o_cnt = r_cnt;
endmodule
`default_nettype wire

// File: rtl/demux4_slot.sv
`default_nettype none
// ---------------------------------------------------------------------------
// demux4_slot : registered 1-to-4 demultiplexer with per-channel handshake
// Revision 1.0
// ---------------------------------------------------------------------------
module demux4_slot
  import demux4_slot_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  wire logic         clk,
  input  wire logic         rst,
  demux4_slot_if.slave      bus
);
  logic [NCH-1:0]          w_sel;
  logic [NCH-1:0]          w_free;
  logic [NCH-1:0]          w_load;
  logic [NCH-1:0][W-1:0]   w_y;
  logic [NCH-1:0]          w_v;
  logic [NCH-1:0][CW-1:0]  w_cnt;

  assign w_sel   = ch_decode(bus.s);
  assign bus.rdy = w_free[bus.s];

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_slot
      assign w_load[g] = bus.en & w_sel[g] & w_free[g];

      demux_slot #(
        .W  (W),
        .CW (CW)
      ) u_slot (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load[g]),
        .i_load_data (bus.din),
        .i_sink_rdy  (bus.r[g]),
        .o_free      (w_free[g]),
        .o_y         (w_y[g]),
        .o_v         (w_v[g]),
        .o_cnt       (w_cnt[g])
      );
    end
  endgenerate

  assign bus.y   = w_y;
  assign bus.v   = w_v;
  assign bus.cnt = w_cnt;
endmodule
`default_nettype wire

// File: tb/tb_demux4_slot.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_demux4_slot : directed self-checking bench for demux4_slot
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_demux4_slot;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   exp_cnt3;

  demux4_slot_if #(.W(2), .CW(8)) bus ();

  demux4_slot #(.W(2), .CW(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.din  = '0;
    bus.s    = 2'd0;
    bus.en   = 1'b0;
    bus.r    = 4'b0000;

    // reset state
    tick();
    tick();
    check("rst_v",    bus.v, 4'b0000);
    check("rst_cnt0", bus.cnt[0], 8'd0);
    check("rst_y",    {bus.y[3], bus.y[2], bus.y[1], bus.y[0]}, 8'h00);
    check("rst_rdy",  bus.rdy, 1'b1);
    rst = 1'b0;

    // routing: word i into slot i, no sink ready
    for (int i = 0; i < 4; i++) begin
      bus.din = 2'(i);
      bus.s   = 2'(i);
      bus.en  = 1'b1;
      #1;
      check($sformatf("route_rdy%0d", i), bus.rdy, 1'b1);
      tick();
      check($sformatf("route_y%0d", i), bus.y[i], 32'(i));
      check($sformatf("route_v%0d", i), bus.v, 32'((1 << (i + 1)) - 1));
    end
    bus.en  = 1'b0;
    bus.s   = 2'd0;
    bus.din = 2'd3;
    tick();
    check("en0_y0", bus.y[0], 2'd0);
    check("en0_v",  bus.v, 4'b1111);
    check("en0_cnt1", bus.cnt[1], 8'd0);

    // backpressure on slot 1
    bus.s   = 2'd1;
    bus.din = 2'd2;
    bus.en  = 1'b1;
    #1;
    check("bp_rdy0", bus.rdy, 1'b0);
    tick();
    check("bp_y1_hold", bus.y[1], 2'd1);
    check("bp_v1_hold", bus.v[1], 1'b1);
    bus.r[1] = 1'b1;
    #1;
    check("bp_rdy1", bus.rdy, 1'b1);
    tick();
    check("bp_y1_new", bus.y[1], 2'd2);
    check("bp_v1_new", bus.v[1], 1'b1);
    check("bp_cnt1",   bus.cnt[1], 8'd1);
    bus.en = 1'b0;
    bus.r  = 4'b0000;

    // empty slot 3 before streaming
    bus.r[3] = 1'b1;
    tick();
    check("pre_v3",   bus.v[3], 1'b0);
    check("pre_cnt3", bus.cnt[3], 8'd1);
    exp_cnt3 = 1;

    // streaming into slot 3 with sink always ready
    bus.s  = 2'd3;
    bus.en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.din = 2'(k);
      #1;
      check($sformatf("stream_rdy%0d", k), bus.rdy, 1'b1);
      tick();
      check($sformatf("stream_v%0d", k), bus.v[3], 1'b1);
      check($sformatf("stream_y%0d", k), bus.y[3], 32'(k % 4));
    end
    exp_cnt3 = exp_cnt3 + 9;
    check("stream_cnt3", bus.cnt[3], 32'(exp_cnt3));
    bus.en = 1'b0;
    tick();
    exp_cnt3 = exp_cnt3 + 1;
    check("stream_tail_v3",   bus.v[3], 1'b0);
    check("stream_tail_cnt3", bus.cnt[3], 32'(exp_cnt3));
    check("stream_tail_y3",   bus.y[3], 2'd1);
    bus.r = 4'b0000;

    // slot 0 streams 255 deliveries
    bus.s   = 2'd0;
    bus.din = 2'd1;
    bus.en  = 1'b1;
    bus.r[0] = 1'b1;
    for (int k = 0; k < 255; k++) tick();
    check("wrap_cnt0_255", bus.cnt[0], 8'd255);
    check("wrap_v0", bus.v[0], 1'b1);

    // one edge: drain 0,1,2 and accept into 3
    bus.s   = 2'd3;
    bus.din = 2'd2;
    bus.en  = 1'b1;
    bus.r   = 4'b0111;
    tick();
    check("wrap_cnt0_0", bus.cnt[0], 8'd0);
    check("conc_v",      bus.v, 4'b1000);
    check("conc_cnt1",   bus.cnt[1], 8'd2);
    check("conc_cnt2",   bus.cnt[2], 8'd1);
    check("conc_cnt3",   bus.cnt[3], 32'(exp_cnt3));
    check("conc_y3",     bus.y[3], 2'd2);
    bus.en = 1'b0;
    bus.r  = 4'b0000;

    // asynchronous reset with slot 2 full
    bus.s   = 2'd2;
    bus.din = 2'd3;
    bus.en  = 1'b1;
    tick();
    check("arst_pre_v2", bus.v[2], 1'b1);
    bus.en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_v",    bus.v, 4'b0000);
    check("arst_cnt",  {bus.cnt[3], bus.cnt[2], bus.cnt[1], bus.cnt[0]}, 32'd0);
    check("arst_y",    {bus.y[3], bus.y[2], bus.y[1], bus.y[0]}, 8'h00);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.s = 2'(i);
      #1;
      check($sformatf("post_rst_rdy%0d", i), bus.rdy, 1'b1);
    end
    bus.s   = 2'd2;
    bus.din = 2'd1;
    bus.en  = 1'b1;
    tick();
    check("post_rst_v2", bus.v, 4'b0100);
    check("post_rst_y2", bus.y[2], 2'd1);
    bus.en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
